// File: rtl/h2b_pkg.sv
// h2b_pkg: shared definitions for the host-to-breakout serial link.
// Holds the frame field widths, the bit positions of each field inside the
// 16-bit frame, and the frame-pack function. The host transmitter uses the
// pack function, and so do the breakout receiver and its checker.
package h2b_pkg;

   localparam int FRAME_W   = 16;
   localparam int SYNC_W    = 3;
   localparam int PORT_W    = 8;
   localparam int LED_W     = 4;
   localparam int BIT_IDX_W = $clog2(FRAME_W);

   // Field positions inside the frame (bit 15 is transmitted first).
   localparam int SYNC_MSB   = 15;
   localparam int SYNC_LSB   = 13;
   localparam int PORT_MSB   = 12;
   localparam int PORT_LSB   = 5;
   localparam int LED_MSB    = 4;
   localparam int LED_LSB    = 1;
   localparam int PARITY_BIT = 0;

   localparam logic [SYNC_W-1:0] SYNC_DEFAULT = 3'b110;

   typedef logic [FRAME_W-1:0] frame_t;

   // Builds a frame from a port word and an LED word. The parity bit is the
   // even parity of the port and LED fields, so the count of ones across
   // bits [12:0] is always even.
   function automatic frame_t pack_frame(input logic [PORT_W-1:0] port,
                                         input logic [LED_W-1:0]  led,
                                         input logic [SYNC_W-1:0] sync = SYNC_DEFAULT);
      frame_t f;
      f                    = '0;
      f[SYNC_MSB:SYNC_LSB] = sync;
      f[PORT_MSB:PORT_LSB] = port;
      f[LED_MSB:LED_LSB]   = led;
      f[PARITY_BIT]        = ^{port, led};
      return f;
   endfunction

endpackage

// File: rtl/bit_timer.sv
// bit_timer: phase and bit-index counters for the host-to-breakout serializer.
// Ports:
//   i_clk, i_reset_n : system clock, asynchronous active-low reset
//   o_clk_s          : registered forwarded bit clock (low for the first half
//                      of each bit period, high for the second half)
//   o_load           : strobe, the coming clock edge starts a new frame
//   o_shift          : strobe, the coming clock edge moves to the next bit
module bit_timer
   import h2b_pkg::*;
#(
   parameter int HALF_PERIOD = 1
)
(
   input  logic i_clk,
   input  logic i_reset_n,
   output logic o_clk_s,
   output logic o_load,
   output logic o_shift
);

   localparam int PH_W = $clog2(2 * HALF_PERIOD);
   localparam logic [PH_W-1:0]      PH_MAX  = PH_W'(2 * HALF_PERIOD - 1);
   localparam logic [PH_W-1:0]      PH_HALF = PH_W'(HALF_PERIOD);
   localparam logic [BIT_IDX_W-1:0] B_TOP   = BIT_IDX_W'(FRAME_W - 1);

   logic [PH_W-1:0]      ph_reg;
   logic [PH_W-1:0]      ph_next;
   logic [BIT_IDX_W-1:0] b_reg;
   logic [BIT_IDX_W-1:0] b_next;
   logic                 running_reg;
   logic                 ph_wrap;

   assign ph_wrap = (ph_reg == PH_MAX);

   // The very first edge after reset release also counts as a frame
   // boundary: it launches frame bit 15 without waiting a full frame.
   assign o_load  = !running_reg || (ph_wrap && (b_reg == '0));
   assign o_shift = running_reg && ph_wrap && (b_reg != '0);

   always_comb begin
      ph_next = ph_reg;
      b_next  = b_reg;
      if (running_reg) begin
         if (ph_wrap) begin
            ph_next = '0;
            b_next  = (b_reg == '0) ? B_TOP : b_reg - BIT_IDX_W'(1);
         end else begin
            ph_next = ph_reg + PH_W'(1);
         end
      end
   end

   // Reset release is expected to be synchronous to i_clk at the source.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ph_reg      <= '0;
         b_reg       <= B_TOP;
         running_reg <= 1'b0;
         o_clk_s     <= 1'b0;
      end else begin
         ph_reg      <= ph_next;
         b_reg       <= b_next;
         running_reg <= 1'b1;
         // Registered from the next phase so the clock and data change on
         // the same edge; data only ever changes when this goes low.
         o_clk_s     <= (ph_next >= PH_HALF);
      end
   end

endmodule

// File: rtl/host_to_breakout_tx.sv
// host_to_breakout_tx: frames digital-output and link-LED state into a
// continuously repeating 16-bit frame, sent MSB first with a forwarded clock.
// Ports:
//   i_clk, i_reset_n      : system clock, asynchronous active-low reset
//   i_port, i_led, i_valid: new output word and its valid strobe
//   o_ready               : one-deep holding register is free
//   o_clk_s, o_d0_s       : forwarded bit clock and serial data
//   o_frame_start         : one-cycle pulse when frame bit 15 is first driven
//   o_frame_cnt           : frames started since reset (wrapping)
module host_to_breakout_tx
   import h2b_pkg::*;
#(
   parameter int                HALF_PERIOD = 1,
   parameter logic [SYNC_W-1:0] SYNC_WORD   = SYNC_DEFAULT
)
(
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic [PORT_W-1:0] i_port,
   input  logic [LED_W-1:0]  i_led,
   input  logic              i_valid,
   output logic              o_ready,
   output logic              o_clk_s,
   output logic              o_d0_s,
   output logic              o_frame_start,
   output logic [15:0]       o_frame_cnt
);

   logic              load;
   logic              shift;
   logic              accept;
   logic [PORT_W-1:0] hold_port_reg;
   logic [LED_W-1:0]  hold_led_reg;
   logic              pending_reg;
   frame_t            shift_reg;
   frame_t            frame_next;
   logic              frame_start_reg;
   logic [15:0]       frame_cnt_reg;

   bit_timer #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_bit_timer (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .o_clk_s   (o_clk_s),
      .o_load    (load),
      .o_shift   (shift)
   );

   assign o_ready = !pending_reg;
   assign accept  = i_valid && !pending_reg;

   // A word arriving on the load edge goes straight into the new frame.
   always_comb begin
      frame_next = pack_frame(hold_port_reg, hold_led_reg, SYNC_WORD);
      if (accept) begin
         frame_next = pack_frame(i_port, i_led, SYNC_WORD);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         hold_port_reg   <= '0;
         hold_led_reg    <= '0;
         pending_reg     <= 1'b0;
         shift_reg       <= '0;
         frame_start_reg <= 1'b0;
         frame_cnt_reg   <= '0;
      end else begin
         frame_start_reg <= load;
         // The holding register always keeps the latest word so that idle
         // frames keep retransmitting it.
         if (accept) begin
            hold_port_reg <= i_port;
            hold_led_reg  <= i_led;
         end
         if (load) begin
            shift_reg     <= frame_next;
            pending_reg   <= 1'b0;
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
         end else begin
            if (accept) begin
               pending_reg <= 1'b1;
            end
            if (shift) begin
               shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
            end
         end
      end
   end

   assign o_d0_s        = shift_reg[FRAME_W-1];
   assign o_frame_start = frame_start_reg;
   assign o_frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_host_to_breakout_tx.sv
// Testbench for host_to_breakout_tx: one instance with HALF_PERIOD=1 and one
// with HALF_PERIOD=3. Stimulus pushes hand-computed frames into a queue per
// instance; a receiver monitor decodes frames on rising o_clk_s and compares.
module tb_host_to_breakout_tx;

   logic        clk = 1'b0;
   logic        rst1_n = 1'b0;
   logic        rst3_n = 1'b0;
   logic [7:0]  port1 = '0, port3 = '0;
   logic [3:0]  led1 = '0, led3 = '0;
   logic        valid1 = 1'b0, valid3 = 1'b0;
   logic        ready1, ready3, clks1, clks3, d01, d03, fs1, fs3;
   logic [15:0] cnt1, cnt3;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;

   logic [15:0] exp_q1[$];
   logic [15:0] exp_q3[$];

   // receiver model state, index 0 = HALF_PERIOD 1, index 1 = HALF_PERIOD 3
   int          half_tab[2] = '{1, 3};
   logic        prev_clk[2];
   logic        prev_d0[2];
   int          bitcnt[2];
   logic [15:0] rx[2];
   int          last_rise[2];
   int          last_chg[2];
   int          last_fs[2];
   logic [15:0] exp_cnt[2];

   host_to_breakout_tx #(.HALF_PERIOD(1), .SYNC_WORD(3'b110)) u_dut1 (
      .i_clk(clk), .i_reset_n(rst1_n), .i_port(port1), .i_led(led1),
      .i_valid(valid1), .o_ready(ready1), .o_clk_s(clks1), .o_d0_s(d01),
      .o_frame_start(fs1), .o_frame_cnt(cnt1));

   host_to_breakout_tx #(.HALF_PERIOD(3), .SYNC_WORD(3'b110)) u_dut3 (
      .i_clk(clk), .i_reset_n(rst3_n), .i_port(port3), .i_led(led3),
      .i_valid(valid3), .o_ready(ready3), .o_clk_s(clks3), .o_d0_s(d03),
      .o_frame_start(fs3), .o_frame_cnt(cnt3));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic chk_ge(input string name, input int act, input int min);
      total_cnt++;
      if (act >= min) pass_cnt++;
      else $display("FAIL %s: got %0d cycles, expected at least %0d", name, act, min);
   endtask

   task automatic mon(input int k, input logic rst_n, input logic clk_s,
                      input logic d0, input logic fs, input logic [15:0] cnt);
      logic [15:0] exp_f;
      if (!rst_n) begin
         prev_clk[k]  = 1'b0;
         prev_d0[k]   = 1'b0;
         bitcnt[k]    = 0;
         last_rise[k] = -1000;
         last_chg[k]  = -1000;
         last_fs[k]   = -1;
         exp_cnt[k]   = '0;
         return;
      end
      if (fs) begin
         exp_cnt[k] = exp_cnt[k] + 16'd1;
         chk($sformatf("dut%0d_frame_cnt", k), {16'd0, cnt}, {16'd0, exp_cnt[k]});
         if (last_fs[k] >= 0)
            chk($sformatf("dut%0d_frame_period", k), cyc - last_fs[k], 32 * half_tab[k]);
         last_fs[k] = cyc;
         bitcnt[k]  = 0;
      end
      if (d0 !== prev_d0[k]) begin
         chk_ge($sformatf("dut%0d_d0_hold", k), cyc - last_rise[k], half_tab[k]);
         last_chg[k] = cyc;
      end
      if (clk_s && !prev_clk[k]) begin
         if (last_rise[k] >= 0)
            chk($sformatf("dut%0d_clk_period", k), cyc - last_rise[k], 2 * half_tab[k]);
         chk_ge($sformatf("dut%0d_d0_setup", k), cyc - last_chg[k], half_tab[k]);
         last_rise[k] = cyc;
         rx[k] = {rx[k][14:0], d0};
         bitcnt[k]++;
         if (bitcnt[k] == 16) begin
            bitcnt[k] = 0;
            if (k == 0 && exp_q1.size() > 0) begin
               exp_f = exp_q1.pop_front();
               chk("dut0_frame", {16'd0, rx[k]}, {16'd0, exp_f});
               $display("dut0 frame 0x%04h expected 0x%04h", rx[k], exp_f);
            end else if (k == 1 && exp_q3.size() > 0) begin
               exp_f = exp_q3.pop_front();
               chk("dut1_frame", {16'd0, rx[k]}, {16'd0, exp_f});
               $display("dut1 frame 0x%04h expected 0x%04h", rx[k], exp_f);
            end
         end
      end
      prev_clk[k] = clk_s;
      prev_d0[k]  = d0;
   endtask

   always @(negedge clk) begin
      mon(0, rst1_n, clks1, d01, fs1, cnt1);
      mon(1, rst3_n, clks3, d03, fs3, cnt3);
   end

   task automatic wait_fs(input int k, input int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if ((k == 0 && fs1) || (k == 1 && fs3)) return;
      end
      total_cnt++;
      $display("FAIL dut%0d_frame_start_timeout: got none in %0d cycles, expected a pulse", k, limit);
   endtask

   task automatic chk_reset1(input string tag);
      chk({tag, "_clk_s"}, clks1, 0);
      chk({tag, "_d0"}, d01, 0);
      chk({tag, "_ready"}, ready1, 1);
      chk({tag, "_frame_start"}, fs1, 0);
      chk({tag, "_frame_cnt"}, cnt1, 0);
   endtask

   task automatic run1();
      int stall;
      repeat (3) @(negedge clk);
      chk_reset1("rst");
      repeat (3) exp_q1.push_back(16'hC000);
      rst1_n = 1'b1;
      @(negedge clk);
      chk("first_frame_start", fs1, 1);
      chk("first_d0", d01, 1);
      wait_fs(0, 100);
      wait_fs(0, 100);
      // frame 3: write mid-frame
      repeat (5) @(negedge clk);
      port1 = 8'hA5; led1 = 4'h3; valid1 = 1'b1;
      exp_q1.push_back(16'hD4A6);
      $display("write port=0xA5 led=0x3 mid-frame");
      @(negedge clk);
      valid1 = 1'b0;
      chk("ready_after_write", ready1, 0);
      repeat (25) @(negedge clk);
      chk("ready_in_load_pending", ready1, 0);
      @(negedge clk);
      chk("ready_after_load", ready1, 1);
      chk("boundary_frame_start", fs1, 1);
      // frame 5: idle retransmit, write in its load cycle
      exp_q1.push_back(16'hD4A6);
      wait_fs(0, 100);
      repeat (31) @(negedge clk);
      chk("ready_in_load", ready1, 1);
      port1 = 8'hFF; led1 = 4'h1; valid1 = 1'b1;
      exp_q1.push_back(16'hDFE3);
      $display("write port=0xFF led=0x1 in load cycle");
      @(negedge clk);
      valid1 = 1'b0;
      chk("ready_after_bypass", ready1, 1);
      chk("bypass_frame_start", fs1, 1);
      repeat (10) @(negedge clk);
      chk("ready_bypass_later", ready1, 1);
      // frame 7: two back-to-back writes
      exp_q1.push_back(16'hDFE3);
      wait_fs(0, 100);
      repeat (2) @(negedge clk);
      port1 = 8'h11; led1 = 4'h0; valid1 = 1'b1;
      exp_q1.push_back(16'hC220);
      $display("write port=0x11 led=0x0");
      @(negedge clk);
      valid1 = 1'b0;
      chk("ready_first_write", ready1, 0);
      @(negedge clk);
      port1 = 8'h22; led1 = 4'hF; valid1 = 1'b1;
      exp_q1.push_back(16'hC45E);
      $display("write port=0x22 led=0xF (stalls)");
      stall = 0;
      for (int i = 0; i < 100 && !ready1; i++) begin
         stall++;
         @(negedge clk);
      end
      chk("stall_cycles", stall, 28);
      chk("stall_release_at_boundary", fs1, 1);
      @(negedge clk);
      valid1 = 1'b0;
      chk("ready_second_write", ready1, 0);
      // frame 9 carries 0x22; reset in frame 10 at b=7
      wait_fs(0, 100);
      wait_fs(0, 100);
      repeat (16) @(negedge clk);
      rst1_n = 1'b0;
      $display("reset asserted mid-frame");
      #1;
      chk_reset1("midrst");
      repeat (2) @(negedge clk);
      repeat (2) exp_q1.push_back(16'hC000);
      rst1_n = 1'b1;
      @(negedge clk);
      chk("restart_frame_start", fs1, 1);
      repeat (5) @(negedge clk);
      u_dut1.frame_cnt_reg = 16'hFFFF;
      exp_cnt[0] = 16'hFFFF;
      wait_fs(0, 100);
      chk("cnt_wrap", cnt1, 0);
      wait_fs(0, 100);
   endtask

   task automatic run3();
      repeat (3) @(negedge clk);
      exp_q3.push_back(16'hC000);
      rst3_n = 1'b1;
      @(negedge clk);
      chk("h3_first_frame_start", fs3, 1);
      repeat (10) @(negedge clk);
      port3 = 8'h3C; led3 = 4'h5; valid3 = 1'b1;
      exp_q3.push_back(16'hC78A);
      $display("h3 write port=0x3C led=0x5");
      @(negedge clk);
      valid3 = 1'b0;
      wait_fs(1, 300);
      repeat (40) @(negedge clk);
      port3 = 8'h81; led3 = 4'hA; valid3 = 1'b1;
      exp_q3.push_back(16'hD034);
      $display("h3 write port=0x81 led=0xA");
      @(negedge clk);
      valid3 = 1'b0;
      wait_fs(1, 300);
      wait_fs(1, 300);
   endtask

   initial begin
      fork
         run1();
         run3();
      join
      @(negedge clk);
      chk("dut0_queue_drained", exp_q1.size(), 0);
      chk("dut1_queue_drained", exp_q3.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/host_to_breakout_tx.md
Name: host_to_breakout_tx

Overview:
Host-side serializer for the host-to-breakout link. It frames digital-output and link-LED state into a continuously repeating 16-bit frame. It drives a forwarded bit clock and one data line toward the breakout's host_to_breakout receiver. State is sent every frame whether or not it changed; new values enter through a one-deep valid/ready holding register.

Parameters:
HALF_PERIOD, 1, i_clk cycles per half bit period (bit period = 2*HALF_PERIOD cycles); legal range 1..255
SYNC_WORD, 3'b110, sync pattern sent in frame bits [15:13]

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_port  input  8  digital-output word to send (dout7..dout0)
i_led  input  4  link LED word to send (led3..led0)
i_valid  input  1  i_port/i_led valid this cycle
o_ready  output  1  holding register can accept a word
o_clk_s  output  1  forwarded bit clock; receiver samples o_d0_s on its rising edge
o_d0_s  output  1  serial data, MSB first
o_frame_start  output  1  one-cycle pulse in the cycle frame bit 15 is first driven
o_frame_cnt  output  16  frames started since reset, wraps at 0xFFFF -> 0x0000

Behaviour:
- Frame, MSB first:
  - [15:13] SYNC_WORD
  - [12:5] i_port[7:0]
  - [4:1] i_led[3:0]
  - [0] even parity: XOR of bits [12:1], so ones across [12:0] are even.
- Counters:
  - phase ph counts 0..2*HALF_PERIOD-1.
  - bit index b counts 15 down to 0; decrement when ph wraps.
  - Frame ends when b=0 and ph wraps; the next frame restarts at b=15.
- Outputs: all registered; no combinational path from inputs to outputs except o_ready.
  - o_clk_s = 0 while ph < HALF_PERIOD, else 1.
  - o_d0_s changes only on cycles where o_clk_s goes low, giving a full half period of setup/hold at the receiver.
- Reset (async assert, sync release):
  - o_clk_s=0, o_d0_s=0, o_ready=1, o_frame_start=0, o_frame_cnt=0.
  - Holding register = 12'h000, pending=0, ph=0, b=15.
- First frame:
  - Starts on the first i_clk edge after reset deassertion.
  - That cycle: o_d0_s = frame bit 15 of the holding value (0xC000 frame), o_frame_start=1, o_frame_cnt -> 1.
- Handshake:
  - o_ready = !pending.
  - Word accepted when i_valid & o_ready at a clock edge; it is written to the holding register and pending is set.
  - While pending, i_valid is ignored and the held word is retained.
- Load cycle: the last cycle of a frame (b=0, ph=2*HALF_PERIOD-1).
  - The shift register loads the frame from the holding register; pending clears.
  - A word accepted in the load cycle bypasses the holding register: it goes directly into the next frame and pending stays 0.
  - A word accepted in any other cycle goes into the next frame boundary, not the current frame.
- Idle: with no new words, the last word is retransmitted every frame indefinitely.
- Latency: an accepted word appears on o_d0_s (bit 12) within at most 1 frame + 3 bit periods.
- Reset mid-frame: outputs go to reset values immediately; the partial frame is abandoned; after release a fresh frame starts from b=15 with holding=0.
- o_frame_cnt increments with each o_frame_start pulse; 0xFFFF wraps to 0x0000.

Decomposition:
- Shared package h2b_pkg holds:
  - FRAME_W=16, SYNC_W=3, PORT_W=8, LED_W=4
  - bit-position constants for sync, port, LED and parity fields
  - a frame-pack function (port, led -> 16-bit frame with parity), reused by the breakout-side receiver and its checker.
- One natural sub-module: bit_timer, the ph/b counters generating o_clk_s, shift and load strobes.

Test Plan:
- Reset then idle, HALF_PERIOD=1 -> frames repeat 0xC000 every 32 cycles; o_clk_s period 2 cycles; o_frame_start pulse every 32 cycles; o_frame_cnt=1,2,3...
- Write port=0xA5, led=0x3 mid-frame -> next frame decodes 0xD4A6; o_ready low until that frame's load cycle.
- Write port=0xFF, led=0x1 exactly in the load cycle -> immediately following frame is 0xDFE3; o_ready never deasserts.
- Two back-to-back writes (0x11/0x0, then 0x22/0xF) in one frame -> second write stalls (o_ready=0) until the load; frames carry 0x11 then 0x22 in order.
- HALF_PERIOD=3 with a receiver model sampling on rising o_clk_s -> every o_d0_s transition is ≥3 cycles from any rising edge; decoded frames match the pack function and parity checks pass.
- Assert i_reset_n low at b=7 -> outputs at reset values in the same cycle; after release, first frame is 0xC000; preload o_frame_cnt to 0xFFFF and check it wraps to 0x0000 on the next frame.
